conv_row_sequencer: RTL and testbench
=====================================

Name: conv_row_sequencer

Overview:
Frame-level controller for the sliding-window convolution datapath. On `start` it steps the 3-row line-buffer loader through every vertical window position. For each window it waits for the loader's `loaded` acknowledge, then sweeps the horizontal window index across all valid columns to the MAC stage under a valid/ready handshake. It drains the MAC pipeline after each row and signals frame completion.

Parameters:
- IMAGE_WIDTH, 128, pixels per image row.
- IMAGE_HEIGHT, 128, rows per image.
- FILTER_SIZE, 3, kernel edge length; OUT_ROWS = IMAGE_HEIGHT-FILTER_SIZE+1, OUT_COLS = IMAGE_WIDTH-FILTER_SIZE+1.
- PIPE_LAT, 4, MAC pipeline depth in cycles; drain wait after the last column of a row.
- TIMEOUT, 64, cycles allowed between buf_next and buf_loaded (used only with the optional feature).

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, synchronous active-low reset.
- start, in, 1, one-cycle frame start; ignored unless in IDLE.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse when the frame completes.
- err, out, 1, one-cycle pulse on loader timeout; constant 0 without SEQ_TIMEOUT_EN.
- buf_next, out, 1, one-cycle pulse to the loader's new_buffer: load the next 3-row window and advance.
- buf_loaded, in, 1, loader acknowledge; window data valid.
- row_idx, out, $clog2(IMAGE_HEIGHT), current output row 0..OUT_ROWS-1.
- col_idx, out, $clog2(IMAGE_WIDTH), current window column 0..OUT_COLS-1.
- win_valid, out, 1, row_idx/col_idx name a valid window for the MAC.
- win_ready, in, 1, MAC accepts the window this cycle.
- last_col, out, 1, high with win_valid when col_idx == OUT_COLS-1.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; busy, done, err, buf_next, win_valid and last_col = 0; row_idx = col_idx = 0; drain and timeout counters = 0.
  - Reset mid-frame aborts immediately with no done pulse. The loader shares rst, so its row counter realigns to 0.
- States:
  - IDLE:
    - start=1 -> REQ; row_idx <= 0, col_idx <= 0.
  - REQ:
    - Assert buf_next for exactly this one cycle -> WAIT_LD.
  - WAIT_LD:
    - buf_next=0. On buf_loaded=1 -> SWEEP.
    - buf_loaded is sampled only in this state; pulses in other states are ignored.
  - SWEEP:
    - win_valid=1 and last_col = (col_idx==OUT_COLS-1).
    - A transfer occurs when win_valid & win_ready at the edge.
    - On transfer with col_idx < OUT_COLS-1: col_idx <= col_idx+1.
    - On transfer with col_idx == OUT_COLS-1: col_idx <= 0, drain counter <= 0 -> DRAIN.
    - win_ready=0 holds col_idx and win_valid; no window is skipped or repeated.
  - DRAIN:
    - win_valid=0. Counter increments each cycle. After PIPE_LAT cycles in DRAIN -> NEXT.
  - NEXT:
    - If row_idx == OUT_ROWS-1 -> DONE.
    - Else row_idx <= row_idx+1 -> REQ.
  - DONE:
    - done=1 for one cycle -> IDLE. row_idx is left at OUT_ROWS-1 until the next start.
- Latency:
  - start to first buf_next is 1 cycle.
  - buf_loaded to first win_valid is 1 cycle.
  - With win_ready tied high, each row takes 1 (REQ) + loader ack + OUT_COLS + PIPE_LAT + 1 cycles.
- Loader pulse count: buf_next pulses exactly OUT_ROWS times per frame. With 128/3 defaults that is 126, which leaves the loader's row counter wrapped back to 0 for the next frame.
- Widths: counters are sized to the ranges above, and comparisons use parameter-derived constants. OUT_COLS=1 is legal: the first transfer goes straight to DRAIN.
- Simultaneous events:
  - start while busy is ignored.
  - win_ready with win_valid=0 has no effect.

Optional Feature:
SEQ_TIMEOUT_EN:
- Defined: a timeout counter clears on entry to WAIT_LD and increments each cycle there. If it reaches TIMEOUT without buf_loaded, the sequencer pulses err for one cycle and returns to IDLE; done is not pulsed and busy drops. A buf_loaded in the same cycle the counter reaches TIMEOUT wins, and the sequencer proceeds to SWEEP.
- Undefined: no counter is built, WAIT_LD waits indefinitely, and err is tied to 0.

Test Plan:
- Reset then a start pulse; loader model acks 1 cycle after each buf_next; win_ready=1 -> 126 buf_next pulses, 126×126 transfers in order (row-major) with row 0..125 and col 0..125, last_col on every col 125, a single done pulse, busy low after.
- Toggle win_ready pseudo-randomly (~50%) during the frame -> the transfer sequence is identical to the previous test with no duplicated or missing (row,col); win_valid never drops mid-row while stalled.
- Delay the loader ack 10 cycles -> no win_valid until 1 cycle after buf_loaded, and no second buf_next during the wait.
- Assert rst=0 at row 40, col 77 -> next cycle busy=0, win_valid=0, row_idx=col_idx=0 and no done. A new start then runs a full 126-row frame.
- Pulse start during SWEEP and pulse buf_loaded spuriously during DRAIN -> no state change and no extra buf_next.
- With SEQ_TIMEOUT_EN and TIMEOUT=64, the loader never acks -> err pulses exactly 64 cycles after entering WAIT_LD, then IDLE with busy=0 and done=0. Without the macro the sequencer stays in WAIT_LD and err stays 0.

Source files
------------

// File: rtl/conv_row_sequencer_if.sv
// ---------------------------------------------------------------------------
// conv_row_sequencer_if
// Handshake bundle between the convolution row sequencer, the line-buffer
// loader and the MAC stage.
//   start      : one-cycle frame start request
//   busy       : sequencer is not idle
//   done       : one-cycle frame completion pulse
//   err        : one-cycle loader timeout pulse
//   buf_next   : one-cycle request to the loader for the next 3-row window
//   buf_loaded : loader acknowledge, window data valid
//   row_idx    : current output row
//   col_idx    : current window column
//   win_valid  : row_idx/col_idx name a valid window for the MAC
//   win_ready  : MAC accepts the window this cycle
//   last_col   : win_valid on the final column of the row
// Modport master is the sequencer side; slave is the environment side.
// ---------------------------------------------------------------------------
interface conv_row_sequencer_if #(
  parameter int ROW_W = 7,
  parameter int COL_W = 7
);
  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic             buf_next;
  logic             buf_loaded;
  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;
  logic             win_valid;
  logic             win_ready;
  logic             last_col;

  modport master (
    input  start, buf_loaded, win_ready,
    output busy, done, err, buf_next, row_idx, col_idx, win_valid, last_col
  );

  modport slave (
    output start, buf_loaded, win_ready,
    input  busy, done, err, buf_next, row_idx, col_idx, win_valid, last_col
  );
endinterface

// File: rtl/conv_row_sequencer.sv
// ---------------------------------------------------------------------------
// conv_row_sequencer
// Frame-level controller for the sliding-window convolution datapath. For
// every vertical window position it requests a 3-row window from the line
// buffer loader, waits for its acknowledge, sweeps every valid column to the
// MAC under valid/ready, drains the MAC pipeline, then moves to the next row.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : conv_row_sequencer_if.master (start/busy/done/err, loader
//         buf_next/buf_loaded, MAC row_idx/col_idx/win_valid/win_ready/
//         last_col)
// Optional build macro SEQ_TIMEOUT_EN: adds a loader acknowledge timeout
// that pulses err and returns to idle. Without it err is tied low and the
// sequencer waits for the loader indefinitely.
// ---------------------------------------------------------------------------
module conv_row_sequencer #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int FILTER_SIZE  = 3,
  parameter int PIPE_LAT     = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_row_sequencer_if.master  bus
);

  localparam int OUT_ROWS = IMAGE_HEIGHT - FILTER_SIZE + 1;
  localparam int OUT_COLS = IMAGE_WIDTH - FILTER_SIZE + 1;
  localparam int ROW_W    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int COL_W    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int DRN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_COLS - 1);
  localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_SWEEP = 3'd3,
    S_DRAIN = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             err_q, err_d;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT > 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Row/column/drain/timeout counters and the registered error pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
      drn_q <= '0;
      err_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      drn_q <= drn_d;
      err_q <= err_d;
`ifdef SEQ_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    drn_d   = drn_q;
    err_d   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_REQ;
          row_d   = '0;
          col_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        // An acknowledge on the timeout cycle itself still wins.
        if (bus.buf_loaded) begin
          state_d = S_SWEEP;
        end else begin
`ifdef SEQ_TIMEOUT_EN
          if (tmo_q == LAST_TMO) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            tmo_d   = tmo_q + TMO_W'(1);
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_SWEEP: begin
        if (bus.win_ready) begin
          if (col_q == LAST_COL) begin
            col_d   = '0;
            drn_d   = '0;
            state_d = S_DRAIN;
          end else begin
            col_d   = col_q + COL_W'(1);
          end
        end else begin
          col_d = col_q;
        end
      end
      S_DRAIN: begin
        if (drn_q == LAST_DRN) begin
          state_d = S_NEXT;
        end else begin
          drn_d   = drn_q + DRN_W'(1);
        end
      end
      S_NEXT: begin
        if (row_q == LAST_ROW) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state and counters
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.buf_next  = (state_q == S_REQ);
    bus.win_valid = (state_q == S_SWEEP);
    bus.last_col  = (state_q == S_SWEEP) && (col_q == LAST_COL);
    bus.done      = (state_q == S_DONE);
    bus.err       = err_q;
    bus.row_idx   = row_q;
    bus.col_idx   = col_q;
  end

endmodule

// File: tb/tb_conv_row_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_row_sequencer
// Self-checking bench for conv_row_sequencer with default parameters
// (128x128 image, 3x3 kernel, PIPE_LAT 4, TIMEOUT 64). Short directed
// vectors come from a table; full frames are checked against a queue of
// expected (row, col, last_col) transfers in row-major order.
// ---------------------------------------------------------------------------
module tb_conv_row_sequencer;

  localparam int OUT_ROWS = 126;
  localparam int OUT_COLS = 126;
  localparam int PIPE_LAT = 4;

  typedef struct {
    int row;
    int col;
    int last;
  } xfer_t;

  typedef struct {
    int start;
    int loaded;
    int ready;
    int busy;
    int bn;
    int wv;
    int last;
    int row;
    int col;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  logic start_r    = 1'b0;
  logic ld_manual  = 1'b0;
  logic ld_model   = 1'b0;
  logic rdy_manual = 1'b0;
  logic rdy_rand   = 1'b0;
  logic loader_en  = 1'b0;
  int   rdy_mode   = 0;
  int   ack_dly    = 1;
  logic sb_en      = 1'b0;

  int   bn_cnt   = 0;
  int   done_cnt = 0;

  xfer_t exp_q[$];
  vec_t  tbl[8];

  logic prev_stall = 1'b0;
  int   prev_row   = 0;
  int   prev_col   = 0;

  conv_row_sequencer_if #(.ROW_W(7), .COL_W(7)) bus ();

  assign bus.start      = start_r;
  assign bus.buf_loaded = loader_en ? ld_model : ld_manual;
  assign bus.win_ready  = (rdy_mode == 0) ? rdy_manual :
                          (rdy_mode == 1) ? 1'b1 : rdy_rand;

  conv_row_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pseudo-random MAC back-pressure
  always begin
    @(posedge clk);
    #1;
    rdy_rand = 1'($urandom % 2);
  end

  // Loader model: acknowledge ack_dly cycles after each buf_next
  always begin
    @(negedge clk);
    if (loader_en && bus.buf_next) begin
      repeat (ack_dly) @(posedge clk);
      #1 ld_model = 1'b1;
      @(posedge clk);
      #1 ld_model = 1'b0;
    end
  end

  // Pulse counters
  always @(negedge clk) begin
    if (bus.buf_next) bn_cnt++;
    if (bus.done) done_cnt++;
  end

  // Transfer scoreboard and stall-hold monitor
  always @(negedge clk) begin
    if (sb_en) begin
      if (prev_stall) begin
        checks++;
        if (!(bus.win_valid && int'(bus.row_idx) == prev_row && int'(bus.col_idx) == prev_col)) begin
          errors++;
          $display("FAIL stall_hold: got wv=%0d row=%0d col=%0d expected wv=1 row=%0d col=%0d",
                   bus.win_valid, bus.row_idx, bus.col_idx, prev_row, prev_col);
        end
      end
      if (bus.win_valid && bus.win_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_extra: got row=%0d col=%0d expected no transfer", bus.row_idx, bus.col_idx);
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          if (int'(bus.row_idx) != e.row || int'(bus.col_idx) != e.col || int'(bus.last_col) != e.last) begin
            errors++;
            $display("FAIL xfer: got row=%0d col=%0d last=%0d expected row=%0d col=%0d last=%0d",
                     bus.row_idx, bus.col_idx, bus.last_col, e.row, e.col, e.last);
          end
        end
      end
      prev_stall = bus.win_valid && !bus.win_ready;
      prev_row   = int'(bus.row_idx);
      prev_col   = int'(bus.col_idx);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic run_frame(input int ack, input int mode, input bit abort);
    bit hit;
    exp_q.delete();
    for (int r = 0; r < OUT_ROWS; r++) begin
      for (int c = 0; c < OUT_COLS; c++) begin
        exp_q.push_back('{r, c, (c == OUT_COLS - 1) ? 1 : 0});
      end
    end
    bn_cnt    = 0;
    done_cnt  = 0;
    ack_dly   = ack;
    loader_en = 1'b1;
    rdy_mode  = mode;
    sb_en     = 1'b1;
    start_r   = 1'b1;
    tick();
    start_r   = 1'b0;
    hit       = 1'b0;
    if (abort) begin
      for (int i = 0; i < 20000; i++) begin
        if (bus.win_valid && bus.row_idx == 7'd40 && bus.col_idx == 7'd77) begin
          hit = 1'b1;
          break;
        end
        tick();
      end
      chk("abort_reached", int'(hit), 1);
      rst = 1'b0;
      tick();
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_wv", int'(bus.win_valid), 0);
      chk("abort_row", int'(bus.row_idx), 0);
      chk("abort_col", int'(bus.col_idx), 0);
      chk("abort_done", int'(bus.done), 0);
      rst = 1'b1;
      sb_en = 1'b0;
      repeat (3) tick();
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle", int'(bus.busy), 0);
    end else begin
      for (int i = 0; i < 60000; i++) begin
        if (bus.done) begin
          hit = 1'b1;
          break;
        end
        tick();
      end
      chk("frame_done_seen", int'(hit), 1);
      chk("frame_done_row", int'(bus.row_idx), OUT_ROWS - 1);
      tick();
      chk("frame_busy_after", int'(bus.busy), 0);
      chk("frame_done_once", int'(bus.done), 0);
      tick();
      sb_en = 1'b0;
      chk("frame_row_kept", int'(bus.row_idx), OUT_ROWS - 1);
      chk("frame_xfers_left", exp_q.size(), 0);
      chk("frame_buf_next_cnt", bn_cnt, OUT_ROWS);
      chk("frame_done_cnt", done_cnt, 1);
    end
    loader_en = 1'b0;
    rdy_mode  = 0;
    exp_q.delete();
  endtask

  initial begin
    // start, loaded, ready -> busy, buf_next, win_valid, last_col, row, col
    tbl[0] = '{1, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 1, 0, 1, 0, 0, 0};
    tbl[5] = '{0, 0, 1, 1, 0, 1, 0, 0, 1};
    tbl[6] = '{1, 0, 1, 1, 0, 1, 0, 0, 2};
    tbl[7] = '{0, 1, 0, 1, 0, 1, 0, 0, 2};

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_buf_next", int'(bus.buf_next), 0);
    chk("rst_wv", int'(bus.win_valid), 0);
    chk("rst_last", int'(bus.last_col), 0);
    chk("rst_row", int'(bus.row_idx), 0);
    chk("rst_col", int'(bus.col_idx), 0);
    rst = 1'b1;
    tick();

    // Directed table: start, ignored start, stall, spurious ack in SWEEP
    for (int i = 0; i < 8; i++) begin
      start_r    = tbl[i].start[0];
      ld_manual  = tbl[i].loaded[0];
      rdy_manual = tbl[i].ready[0];
      tick();
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), tbl[i].busy);
      chk($sformatf("vec%0d_bn", i), int'(bus.buf_next), tbl[i].bn);
      chk($sformatf("vec%0d_wv", i), int'(bus.win_valid), tbl[i].wv);
      chk($sformatf("vec%0d_last", i), int'(bus.last_col), tbl[i].last);
      chk($sformatf("vec%0d_row", i), int'(bus.row_idx), tbl[i].row);
      chk($sformatf("vec%0d_col", i), int'(bus.col_idx), tbl[i].col);
      chk($sformatf("vec%0d_done", i), int'(bus.done), 0);
    end

    // Finish row 0, spurious start/ack in DRAIN, exact drain length
    start_r    = 1'b0;
    ld_manual  = 1'b0;
    rdy_manual = 1'b1;
    repeat (OUT_COLS - 3) tick();
    chk("row0_col_end", int'(bus.col_idx), OUT_COLS - 1);
    chk("row0_last_col", int'(bus.last_col), 1);
    chk("row0_wv_end", int'(bus.win_valid), 1);
    start_r   = 1'b1;
    ld_manual = 1'b1;
    tick();
    chk("drain_wv", int'(bus.win_valid), 0);
    chk("drain_col", int'(bus.col_idx), 0);
    chk("drain_last", int'(bus.last_col), 0);
    chk("drain_busy", int'(bus.busy), 1);
    for (int i = 1; i <= PIPE_LAT; i++) begin
      tick();
      chk($sformatf("drain%0d_bn", i), int'(bus.buf_next), 0);
      chk($sformatf("drain%0d_wv", i), int'(bus.win_valid), 0);
    end
    start_r   = 1'b0;
    ld_manual = 1'b0;
    tick();
    chk("row1_bn", int'(bus.buf_next), 1);
    chk("row1_row", int'(bus.row_idx), 1);
    tick();
    chk("row1_bn_once", int'(bus.buf_next), 0);
    do_reset();

    // Loader acknowledge delayed by 10 cycles
    rdy_manual = 1'b1;
    start_r    = 1'b1;
    tick();
    start_r    = 1'b0;
    chk("dly_req_bn", int'(bus.buf_next), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("dly%0d_wv", i), int'(bus.win_valid), 0);
      chk($sformatf("dly%0d_bn", i), int'(bus.buf_next), 0);
    end
    ld_manual = 1'b1;
    tick();
    ld_manual = 1'b0;
    chk("dly_wv_after_ack", int'(bus.win_valid), 1);
    chk("dly_col0", int'(bus.col_idx), 0);
    do_reset();

    // Loader never acknowledges
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    tick();
`ifdef SEQ_TIMEOUT_EN
    for (int i = 1; i < 64; i++) begin
      tick();
      chk($sformatf("tmo%0d_err", i), int'(bus.err), 0);
      chk($sformatf("tmo%0d_busy", i), int'(bus.busy), 1);
    end
    tick();
    chk("tmo_err_pulse", int'(bus.err), 1);
    chk("tmo_busy", int'(bus.busy), 0);
    chk("tmo_done", int'(bus.done), 0);
    tick();
    chk("tmo_err_one", int'(bus.err), 0);
    chk("tmo_idle", int'(bus.busy), 0);
    // Acknowledge on the timeout cycle wins
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    tick();
    repeat (63) tick();
    ld_manual = 1'b1;
    tick();
    ld_manual = 1'b0;
    chk("tmo_race_wv", int'(bus.win_valid), 1);
    chk("tmo_race_err", int'(bus.err), 0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk($sformatf("wait%0d_err", i), int'(bus.err), 0);
      chk($sformatf("wait%0d_busy", i), int'(bus.busy), 1);
    end
    chk("wait_wv", int'(bus.win_valid), 0);
`endif
    do_reset();
    rdy_manual = 1'b0;

    // Full frames: ready high, random ready, abort, then clean restart
    run_frame(1, 1, 1'b0);
    run_frame(1, 2, 1'b0);
    run_frame(1, 1, 1'b1);
    run_frame(1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
